// File: rtl/fifo_word_gen_if.sv
// FIFO write-port bundle between the word generator and the display FIFO.
// master: generator side (drives wrreq/data, observes full/usedw).
// slave:  FIFO side (accepts wrreq/data, reports full/usedw).
interface fifo_word_gen_if #(
    parameter int DATA_W  = 4,
    parameter int USEDW_W = 4
);
    logic               wrreq;
    logic [DATA_W-1:0]  data;
    logic               full;
    logic [USEDW_W-1:0] usedw;

    modport master (output wrreq, data, input full, usedw);
    modport slave  (input wrreq, data, output full, usedw);
endinterface

// File: rtl/fifo_word_gen.sv
// Write-side word source for the display FIFO.
// Each enabled rate strobe yields one word: a wrapping counter value
// (ENraf=0) or the low bits of an 8-bit Fibonacci LFSR (ENraf=1).
// The word is written one cycle after the strobe when the FIFO has room,
// otherwise it is held (pending) until room appears. Strobes that arrive
// while a word is pending are lost.
// Optional macro FIFO_GEN_DROPCNT_EN: when defined, `drops` counts lost
// strobes (saturating at 255); when undefined, `drops` is tied to zero.
// HIGH_WM must be below 2**USEDW_W; DATA_W must not exceed 8.
module fifo_word_gen #(
    parameter int DATA_W  = 4,
    parameter int USEDW_W = 4,
    parameter int HIGH_WM = 14
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  ENgen,
    input  logic                  ENraf,
    input  logic                  STRB,
    fifo_word_gen_if.master       fifo,
    output logic                  pending,
    output logic [7:0]            drops
);
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [USEDW_W-1:0] HIGH_WM_L = USEDW_W'(HIGH_WM);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  cnt, cnt_nxt;
    logic [7:0]         lfsr, lfsr_nxt, lfsr_adv;
    logic [DATA_W-1:0]  word, word_nxt;
    logic [DATA_W-1:0]  gen_word;
    logic [DATA_W-1:0]  data_nxt;
    logic               wrreq_nxt;
    logic               room;

    // usedw does not yet reflect a write issued this cycle, so a cycle that
    // carries wrreq is treated as having no room; this also keeps wrreq
    // from ever being high on two consecutive cycles.
    assign room = !fifo.full && (fifo.usedw < HIGH_WM_L) && !fifo.wrreq;

    // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    assign lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    assign pending = (state == PEND);

    // Next-state, word generation and write decision.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        lfsr_nxt  = lfsr;
        word_nxt  = word;
        gen_word  = cnt;
        wrreq_nxt = 1'b0;
        data_nxt  = fifo.data;
        unique case (state)
            IDLE: begin
                if (STRB && ENgen) begin
                    if (ENraf) begin
                        lfsr_nxt = lfsr_adv;
                        gen_word = lfsr_adv[DATA_W-1:0];
                    end else begin
                        gen_word = cnt;
                        cnt_nxt  = cnt + 1'b1;
                    end
                    if (room) begin
                        wrreq_nxt = 1'b1;
                        data_nxt  = gen_word;
                    end else begin
                        word_nxt  = gen_word;
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (room) begin
                    wrreq_nxt = 1'b1;
                    data_nxt  = word;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, sequence generators and the registered FIFO write port.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lfsr       <= 8'h01;
            word       <= '0;
            fifo.wrreq <= 1'b0;
            fifo.data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lfsr       <= lfsr_nxt;
            word       <= word_nxt;
            fifo.wrreq <= wrreq_nxt;
            fifo.data  <= data_nxt;
        end
    end

`ifdef FIFO_GEN_DROPCNT_EN
    logic drop_inc;

    // A strobe is lost only when the generator is enabled and a word waits.
    assign drop_inc = (state == PEND) && STRB && ENgen;

    // Saturating lost-strobe counter.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            drops <= 8'h00;
        end else if (drop_inc && (drops != 8'hFF)) begin
            drops <= drops + 8'd1;
        end
    end
`else
    assign drops = 8'h00;
`endif

endmodule

// File: tb/tb_fifo_word_gen.sv
// Self-checking bench for fifo_word_gen: directed scenarios plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_fifo_word_gen;
    localparam int DATA_W  = 4;
    localparam int USEDW_W = 4;
    localparam int HIGH_WM = 14;
`ifdef FIFO_GEN_DROPCNT_EN
    localparam int EXP_DROPS3 = 3;
`else
    localparam int EXP_DROPS3 = 0;
`endif

    logic       CLK   = 1'b0;
    logic       RST_n = 1'b1;
    logic       ENgen = 1'b0;
    logic       ENraf = 1'b0;
    logic       STRB  = 1'b0;
    logic       pending;
    logic [7:0] drops;

    fifo_word_gen_if #(.DATA_W(DATA_W), .USEDW_W(USEDW_W)) fif ();

    fifo_word_gen #(.DATA_W(DATA_W), .USEDW_W(USEDW_W), .HIGH_WM(HIGH_WM)) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .ENgen   (ENgen),
        .ENraf   (ENraf),
        .STRB    (STRB),
        .fifo    (fif),
        .pending (pending),
        .drops   (drops)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt;      // next counter value (0..15)
    logic [7:0] m_lfsr;
    bit         m_pend;
    int         m_word;
    bit         m_wr;
    int         m_data;
    int         m_drops;
    int         mlog[$];    // words the model says get written

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_lfsr = 8'h01; m_pend = 0; m_word = 0;
        m_wr = 0; m_data = 0; m_drops = 0;
    endtask

    // Applies one rising edge using the inputs as they stand before it.
    task automatic model_edge();
        bit room;
        bit nwr;
        int ndata;
        int w;
        if (!RST_n) return;
        room  = !fif.full && (int'(fif.usedw) < HIGH_WM) && !m_wr;
        nwr   = 0;
        ndata = m_data;
        if (!m_pend) begin
            if (STRB && ENgen) begin
                if (ENraf) begin
                    m_lfsr = lfsr_step(m_lfsr);
                    w = int'(m_lfsr) % 16;
                end else begin
                    w = m_cnt;
                    m_cnt = (m_cnt + 1) % 16;
                end
                if (room) begin nwr = 1; ndata = w; end
                else begin m_pend = 1; m_word = w; end
            end
        end else begin
`ifdef FIFO_GEN_DROPCNT_EN
            if (STRB && ENgen && m_drops < 255) m_drops++;
`endif
            if (room) begin nwr = 1; ndata = m_word; m_pend = 0; end
        end
        m_wr = nwr;
        m_data = ndata;
        if (nwr) mlog.push_back(ndata);
    endtask

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        check("wrreq",   32'(fif.wrreq), 32'(m_wr));
        check("data",    32'(fif.data),  32'(m_data));
        check("pending", 32'(pending),   32'(m_pend));
        check("drops",   32'(drops),     32'(m_drops));
    end

    // ---------------- drivers ----------------
    task automatic tick(input bit s);
        STRB = s;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        STRB = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        RST_n = 1'b0;
        model_reset();
        tick(1'b0);
        tick(1'b0);
        RST_n = 1'b1;
    endtask

    initial begin
        logic [3:0] lexp[4] = '{4'h2, 4'h4, 4'h8, 4'h1};
        fif.full  = 1'b0;
        fif.usedw = '0;
        model_reset();
        #1;
        do_reset();

        // Reset values, pinned literally.
        check("rst_wrreq",   32'(fif.wrreq), 0);
        check("rst_data",    32'(fif.data),  0);
        check("rst_pending", 32'(pending),   0);
        check("rst_drops",   32'(drops),     0);

        // Counter mode: 18 strobes, 10 cycles apart.
        ENgen = 1'b1; ENraf = 1'b0;
        mlog.delete();
        for (int k = 0; k < 18; k++) begin
            tick(1'b1);
            check("cnt_latency", 32'(fif.wrreq), 1);
            for (int j = 0; j < 9; j++) tick(1'b0);
        end
        check("cnt_nwrites", mlog.size(), 18);
        for (int i = 0; i < mlog.size() && i < 18; i++)
            check("cnt_seq", mlog[i], i % 16);

        // LFSR mode from reset: 02,04,08,11 -> 2,4,8,1.
        do_reset();
        ENraf = 1'b1;
        mlog.delete();
        for (int k = 0; k < 4; k++) begin
            tick(1'b1);
            tick(1'b0); tick(1'b0);
        end
        check("lfsr_nwrites", mlog.size(), 4);
        for (int i = 0; i < mlog.size() && i < 4; i++)
            check("lfsr_seq", mlog[i], 32'(lexp[i]));

        // Full for 5 cycles after a strobe, then released.
        do_reset();
        ENraf = 1'b0;
        fif.full = 1'b1;
        tick(1'b1);
        for (int k = 0; k < 5; k++) begin
            check("full_pending", 32'(pending), 1);
            check("full_nowr", 32'(fif.wrreq), 0);
            tick(1'b0);
        end
        fif.full = 1'b0;
        tick(1'b0);
        check("full_wr", 32'(fif.wrreq), 1);
        check("full_data", 32'(fif.data), 0);
        check("full_pend_clr", 32'(pending), 0);
        tick(1'b0);

        // High watermark: usedw=14 withholds, 13 lets it through.
        fif.usedw = 4'd14;
        tick(1'b1);
        check("wm_pending", 32'(pending), 1);
        check("wm_nowr", 32'(fif.wrreq), 0);
        fif.usedw = 4'd13;
        tick(1'b0);
        check("wm_wr", 32'(fif.wrreq), 1);
        check("wm_data", 32'(fif.data), 1);
        fif.usedw = '0;
        tick(1'b0);

        // Three strobes lost while a word is pending.
        fif.full = 1'b1;
        tick(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            tick(1'b1);
        end
        check("drops3", 32'(drops), EXP_DROPS3);
        fif.full = 1'b0;
        tick(1'b0);
        check("drop_wr_data", 32'(fif.data), 2);
        tick(1'b0); tick(1'b0);
        tick(1'b1);
        check("drop_next_data", 32'(fif.data), 3);
        tick(1'b0);

        // Reset while pending: word discarded, counter restarts.
        fif.full = 1'b1;
        tick(1'b1);
        tick(1'b0);
        check("pre_rst_pending", 32'(pending), 1);
        do_reset();
        check("rstp_pending", 32'(pending), 0);
        check("rstp_wrreq", 32'(fif.wrreq), 0);
        check("rstp_drops", 32'(drops), 0);
        fif.full = 1'b0;
        tick(1'b0);
        check("rstp_nowr", 32'(fif.wrreq), 0);
        tick(1'b1);
        check("rstp_wr", 32'(fif.wrreq), 1);
        check("rstp_data", 32'(fif.data), 0);

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) ENgen = ~ENgen;
            if ($urandom_range(0, 29) == 0) ENraf = ~ENraf;
            fif.full  = ($urandom_range(0, 4) == 0);
            fif.usedw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 699) == 0) do_reset();
            tick($urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
